// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO and models fixed mult/div latency.
// The result is staged in a pending register and committed on the final busy cycle.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [31:0] md_out
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [63:0] pend_q, pend_d;

    md_op_e      op_e;
    logic        accept;
    logic        sgn_div;
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_div, uq, ur, quo, rem;

    assign op_e   = md_op_e'(op);
    assign busy   = (cnt_q != 4'd0);
    assign accept = start && !busy;

    assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide via magnitudes so MIN/-1 wraps cleanly to MIN instead of overflowing.
    assign sgn_div = (op_e == OP_DIV);
    assign a_mag   = (sgn_div && rs[31]) ? (32'd0 - rs) : rs;
    assign b_mag   = (sgn_div && rt[31]) ? (32'd0 - rt) : rt;
    assign b_div   = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign uq      = a_mag / b_div;
    assign ur      = a_mag % b_div;
    assign quo     = (sgn_div && (rs[31] ^ rt[31])) ? (32'd0 - uq) : uq;
    assign rem     = (sgn_div && rs[31]) ? (32'd0 - ur) : ur;

    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        pend_d = pend_q;
        if (busy) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                hi_d = pend_q[63:32];
                lo_d = pend_q[31:0];
            end
        end else if (accept) begin
            unique case (op_e)
                OP_MULT: begin
                    pend_d = prod_s;
                    cnt_d  = 4'(MULT_CYCLES);
                end
                OP_MULTU: begin
                    pend_d = prod_u;
                    cnt_d  = 4'(MULT_CYCLES);
                end
                OP_DIV, OP_DIVU: begin
                    // Divide by zero recommits the current HI/LO, leaving them unchanged.
                    pend_d = (rt == 32'd0) ? {hi_q, lo_q} : {rem, quo};
                    cnt_d  = 4'(DIV_CYCLES);
                end
                OP_MTHI: hi_d = rs;
                OP_MTLO: lo_d = rs;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= 4'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            pend_q <= 64'd0;
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            pend_q <= pend_d;
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;
    assign md_out = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed and randomized md operations against an arithmetic HI/LO model.
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset, start, rd_sel, busy;
    logic [2:0]  op;
    logic [31:0] rs, rt, hi_out, lo_out, md_out;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_hi, m_lo;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
        .rd_sel(rd_sel), .busy(busy), .hi_out(hi_out), .lo_out(lo_out), .md_out(md_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: HI/LO after an accepted operation, from the arithmetic definitions.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int sa, sb;
        sa = a;
        sb = b;
        case (o)
            3'd1: begin p = longint'(sa) * longint'(sb); {m_hi, m_lo} = p; end
            3'd2: begin p = longint'({32'd0, a}) * longint'({32'd0, b}); {m_hi, m_lo} = p; end
            3'd3: if (b != 0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = a; m_hi = 0;
                end else begin
                    m_lo = sa / sb; m_hi = sa % sb;
                end
            end
            3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    function automatic int lat(input logic [2:0] o);
        if (o == 3'd1 || o == 3'd2) return MC;
        if (o == 3'd3 || o == 3'd4) return DC;
        return 0;
    endfunction

    task automatic check_regs(input string tag);
        check({tag, "_hi"}, hi_out, m_hi);
        check({tag, "_lo"}, lo_out, m_lo);
        rd_sel = 1'b1; #1;
        check({tag, "_md_hi"}, md_out, m_hi);
        rd_sel = 1'b0; #1;
        check({tag, "_md_lo"}, md_out, m_lo);
    endtask

    // Wait for busy to drop, bounded; returns number of busy cycles observed.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        int n;
        start = 1'b1; op = o; rs = a; rt = b;
        step();
        start = 1'b0; op = 3'd0;
        rs = $urandom; rt = $urandom;
        model(o, a, b);
        wait_idle(n);
        check({tag, "_busy_len"}, 32'(n), 32'(lat(o)));
        check_regs(tag);
    endtask

    initial begin
        int n;
        logic [2:0] ro;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; op = 3'd0; rs = 0; rt = 0; rd_sel = 1'b0;
        m_hi = 0; m_lo = 0;
        step(); step();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check_regs("rst");

        // MTHI then MTLO back to back
        start = 1'b1; op = 3'd5; rs = 32'h1234_5678;
        step();
        check("mthi_busy", 32'(busy), 32'd0);
        op = 3'd6; rs = 32'h9ABC_DEF0;
        step();
        start = 1'b0;
        check("mtlo_busy", 32'(busy), 32'd0);
        model(3'd5, 32'h1234_5678, 0);
        model(3'd6, 32'h9ABC_DEF0, 0);
        check_regs("mt");

        do_op("mult",  3'd1, 32'hFFFF_FFFF, 32'd2);
        do_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2);
        do_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2);
        do_op("divu",  3'd4, 32'd7, 32'd2);
        do_op("divmin",3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op("nop",   3'd0, 32'h1111_1111, 32'h2222_2222);
        do_op("rsvd",  3'd7, 32'h3333_3333, 32'h4444_4444);

        do_op("sethi", 3'd5, 32'hAAAA_0000, 0);
        do_op("setlo", 3'd6, 32'h0000_BBBB, 0);
        do_op("div0",  3'd3, 32'h1234_5678, 32'd0);
        do_op("divu0", 3'd4, 32'hFFFF_FFFF, 32'd0);

        // Starts during busy are ignored; operand changes mid-run do not matter
        start = 1'b1; op = 3'd1; rs = 32'h0001_2345; rt = 32'hFFFF_0010;
        step();
        model(3'd1, 32'h0001_2345, 32'hFFFF_0010);
        op = 3'd3; rs = 32'd100; rt = 32'd3;
        step();
        op = 3'd6; rs = 32'hDEAD_BEEF;
        step();
        start = 1'b0; op = 3'd0; rs = 32'h5555_5555; rt = 32'hAAAA_AAAA;
        wait_idle(n);
        check("ign_busy_len", 32'(n + 2), 32'(MC));
        check_regs("ign");

        // Reset during a divide discards the pending result
        start = 1'b1; op = 3'd4; rs = 32'd1000; rt = 32'd7;
        step();
        start = 1'b0; op = 3'd0;
        step(); step(); step();
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_hi = 0; m_lo = 0;
        check("midrst_busy", 32'(busy), 32'd0);
        check_regs("midrst");
        for (int i = 0; i < DC; i++) step();
        check_regs("midrst_after");

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
            do_op("rand", ro, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
